// File: rtl/seq_lock_fsm_if.sv
// Plate-input / sequencer bundle for seq_lock_fsm. The master drives codes,
// programming and clear; the slave (the checker) drives the status outputs.
interface seq_lock_fsm_if #(
  parameter int unsigned W         = 8,
  parameter int unsigned N         = 3,
  parameter int unsigned MAX_TRIES = 3
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = $clog2(N + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  logic          in_valid;
  logic [W-1:0]  plate_in;
  logic          prog_en;
  logic [IW-1:0] prog_idx;
  logic [W-1:0]  prog_data;
  logic          clear;

  logic          done;
  logic          fail;
  logic          alarm;
  logic [SW-1:0] step;
  logic [TW-1:0] tries_left;

  modport master (
    output in_valid, plate_in, prog_en, prog_idx, prog_data, clear,
    input  done, fail, alarm, step, tries_left
  );

  modport slave (
    input  in_valid, plate_in, prog_en, prog_idx, prog_data, clear,
    output done, fail, alarm, step, tries_left
  );
endinterface

// File: rtl/seq_lock_fsm.sv
// Runtime-programmable N-code sequence lock with bounded retries and a timed
// lockout. All status outputs come straight from registers.
module seq_lock_fsm #(
  parameter int unsigned       W              = 8,
  parameter int unsigned       N              = 3,
  parameter logic [N*W-1:0]    SEQ_INIT       = {8'hF0, 8'hCC, 8'hAA},
  parameter int unsigned       MAX_TRIES      = 3,
  parameter int unsigned       LOCKOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  seq_lock_fsm_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = $clog2(N + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [SW-1:0] StepLast = SW'(N - 1);
  localparam logic [SW-1:0] StepDone = SW'(N);
  localparam logic [TW-1:0] TriesMax = TW'(MAX_TRIES);
  localparam logic [CW-1:0] LockLoad = CW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {StCheck, StDone, StLockout} state_e;

  state_e        state_q;
  logic [SW-1:0] step_q;
  logic [TW-1:0] tries_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          fail_q;
  logic          alarm_q;
  logic [W-1:0]  seq_q [N];
  logic [W-1:0]  cur_code;

  // Mux by comparison so any step width works without out-of-range indexing.
  always_comb begin
    cur_code = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (step_q == SW'(k)) cur_code = seq_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StCheck;
      step_q  <= '0;
      tries_q <= TriesMax;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      alarm_q <= 1'b0;
      for (int k = 0; k < int'(N); k++) seq_q[k] <= SEQ_INIT[k*W +: W];
    end else begin
      fail_q <= 1'b0;
      unique case (state_q)
        StCheck: begin
          // Programming has priority: a cycle with prog_en never evaluates a code.
          if (bus.prog_en) begin
            if (step_q == '0) begin
              for (int k = 0; k < int'(N); k++) begin
                if (bus.prog_idx == IW'(k)) seq_q[k] <= bus.prog_data;
              end
            end
          end else if (bus.in_valid) begin
            if (bus.plate_in == cur_code) begin
              if (step_q == StepLast) begin
                state_q <= StDone;
                step_q  <= StepDone;
                done_q  <= 1'b1;
              end else begin
                step_q <= step_q + 1'b1;
              end
            end else begin
              fail_q <= 1'b1;
              step_q <= '0;
              if (tries_q <= TW'(1)) begin
                tries_q <= '0;
                state_q <= StLockout;
                alarm_q <= 1'b1;
                cnt_q   <= LockLoad;
              end else begin
                tries_q <= tries_q - 1'b1;
              end
            end
          end
        end
        StDone: begin
          if (bus.clear) begin
            state_q <= StCheck;
            step_q  <= '0;
            tries_q <= TriesMax;
            done_q  <= 1'b0;
          end
        end
        StLockout: begin
          if (cnt_q <= CW'(1)) begin
            state_q <= StCheck;
            alarm_q <= 1'b0;
            cnt_q   <= '0;
            tries_q <= TriesMax;
            step_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StCheck;
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.alarm      = alarm_q;
  assign bus.step       = step_q;
  assign bus.tries_left = tries_q;
endmodule

// File: tb/tb_seq_lock_fsm.sv
// Bench for seq_lock_fsm: vector table, directed lockout/reset sequences,
// a small-parameter instance, and random traffic against a behavioural model.
module tb_seq_lock_fsm;
  localparam int unsigned WA = 8, NA = 3, MA = 3, LA = 16;
  localparam int unsigned WB = 4, NB = 5, MB = 1, LB = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails = 0;

  always #5 clk = ~clk;

  seq_lock_fsm_if #(.W(WA), .N(NA), .MAX_TRIES(MA)) bus_a ();
  seq_lock_fsm_if #(.W(WB), .N(NB), .MAX_TRIES(MB)) bus_b ();

  seq_lock_fsm #(.W(WA), .N(NA), .SEQ_INIT(24'hF0CCAA), .MAX_TRIES(MA),
                 .LOCKOUT_CYCLES(LA))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  seq_lock_fsm #(.W(WB), .N(NB), .SEQ_INIT(20'h54321), .MAX_TRIES(MB),
                 .LOCKOUT_CYCLES(LB))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Behavioural model of instance A: codes matched, failures, alarm cycles left.
  logic [7:0] m_seq [NA];
  int         m_matched, m_fails, m_lock_left;
  logic       m_fail;

  task automatic model_reset();
    m_seq[0] = 8'hAA; m_seq[1] = 8'hCC; m_seq[2] = 8'hF0;
    m_matched = 0; m_fails = 0; m_lock_left = 0; m_fail = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [7:0] pi, input logic pe,
                            input int pidx, input logic [7:0] pd, input logic clr);
    m_fail = 1'b0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_fails = 0; m_matched = 0; end
    end else if (m_matched == int'(NA)) begin
      if (clr) begin m_matched = 0; m_fails = 0; end
    end else if (pe) begin
      if (m_matched == 0 && pidx < int'(NA)) m_seq[pidx] = pd;
    end else if (iv) begin
      if (pi == m_seq[m_matched]) m_matched++;
      else begin
        m_fail = 1'b1;
        m_matched = 0;
        if (m_fails < int'(MA)) m_fails++;
        if (m_fails == int'(MA)) m_lock_left = LA;
      end
    end
  endtask

  function automatic logic [15:0] exp_a(input logic d, input logic f, input logic a,
                                        input int s, input int t);
    return {9'd0, d, f, a, 2'(s), 2'(t)};
  endfunction

  function automatic logic [15:0] exp_b(input logic d, input logic f, input logic a,
                                        input int s, input int t);
    return {9'd0, d, f, a, 3'(s), 1'(t)};
  endfunction

  function automatic logic [15:0] act_a();
    return {9'd0, bus_a.done, bus_a.fail, bus_a.alarm, bus_a.step, bus_a.tries_left};
  endfunction

  function automatic logic [15:0] act_b();
    return {9'd0, bus_b.done, bus_b.fail, bus_b.alarm, bus_b.step, bus_b.tries_left};
  endfunction

  function automatic logic [15:0] exp_model();
    return exp_a(m_matched == int'(NA), m_fail, m_lock_left > 0, m_matched,
                 int'(MA) - m_fails);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got {done,fail,alarm,step,tries}=%h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic iv, input logic [7:0] pi, input logic pe,
                         input logic [1:0] idx, input logic [7:0] pd, input logic clr);
    bus_a.in_valid = iv; bus_a.plate_in = pi; bus_a.prog_en = pe;
    bus_a.prog_idx = idx; bus_a.prog_data = pd; bus_a.clear = clr;
    model_step(iv, pi, pe, int'(idx), pd, clr);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0; bus_a.prog_en = 1'b0; bus_a.clear = 1'b0;
  endtask

  task automatic code_a(input logic [7:0] pi);
    drive_a(1'b1, pi, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic drive_b(input logic iv, input logic [3:0] pi);
    bus_b.in_valid = iv; bus_b.plate_in = pi;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] pi;
    logic       pe;
    logic [1:0] idx;
    logic [7:0] pd;
    logic       clr;
    logic       d, f, a;
    int         s, t;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [7:0] pi, input logic pe,
                     input logic [1:0] idx, input logic [7:0] pd, input logic clr,
                     input logic d, input logic f, input logic a, input int s, input int t,
                     input string name);
    vec_t v;
    v.iv = iv; v.pi = pi; v.pe = pe; v.idx = idx; v.pd = pd; v.clr = clr;
    v.d = d; v.f = f; v.a = a; v.s = s; v.t = t; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_alarm;
    int guard;
    logic [7:0] pi, pd;
    logic [1:0] idx;
    logic iv, pe, clr;
    int r;

    bus_a.in_valid = 0; bus_a.plate_in = 0; bus_a.prog_en = 0;
    bus_a.prog_idx = 0; bus_a.prog_data = 0; bus_a.clear = 0;
    bus_b.in_valid = 0; bus_b.plate_in = 0; bus_b.prog_en = 0;
    bus_b.prog_idx = 0; bus_b.prog_data = 0; bus_b.clear = 0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("reset_a", act_a(), exp_a(0, 0, 0, 0, 3));
    check("reset_b", act_b(), exp_b(0, 0, 0, 0, 1));

    // Small instance: single try, one-cycle lockout, five-code sequence 1..5.
    drive_b(1'b1, 4'hF);
    check("b_lockout", act_b(), exp_b(0, 1, 1, 0, 0));
    drive_b(1'b0, 4'h0);
    check("b_alarm_one_cycle", act_b(), exp_b(0, 0, 0, 0, 1));
    for (int k = 1; k <= 4; k++) begin
      drive_b(1'b1, 4'(k));
      check("b_step", act_b(), exp_b(0, 0, 0, k, 1));
    end
    drive_b(1'b1, 4'h5);
    check("b_done", act_b(), exp_b(1, 0, 0, 5, 1));

    // Vector table for instance A.
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 3, "seq_code0");
    add(1, 8'hCC, 0, 0, 0, 0, 0, 0, 0, 2, 3, "seq_code1");
    add(1, 8'hF0, 0, 0, 0, 0, 1, 0, 0, 3, 3, "seq_done");
    add(1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 3, 3, "done_ignores_code");
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 3, "clear");
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 3, "retry_code0");
    add(1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 2, "mismatch");
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 2, "fail_one_cycle");
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 2, "after_fail_code0");
    add(1, 8'hCC, 0, 0, 0, 0, 0, 0, 0, 2, 2, "after_fail_code1");
    add(1, 8'hF0, 0, 0, 0, 0, 1, 0, 0, 3, 2, "after_fail_done");
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 3, "clear_rearms");
    add(1, 8'hAA, 1, 2, 8'h5A, 0, 0, 0, 0, 0, 3, "prog_wins_over_code");
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 3, "prog_code0");
    add(0, 8'h00, 1, 0, 8'h11, 0, 0, 0, 0, 1, 3, "prog_at_step1");
    add(1, 8'hCC, 0, 0, 0, 0, 0, 0, 0, 2, 3, "prog_code1");
    add(1, 8'h5A, 0, 0, 0, 0, 1, 0, 0, 3, 3, "prog_new_code_done");
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 3, "prog_clear");
    add(0, 8'h00, 1, 3, 8'h00, 0, 0, 0, 0, 0, 3, "prog_idx_out_of_range");
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 1, 3, "slot0_unchanged");
    add(1, 8'hCC, 0, 0, 0, 0, 0, 0, 0, 2, 3, "slot1_unchanged");
    add(1, 8'h5A, 0, 0, 0, 0, 1, 0, 0, 3, 3, "slot2_kept");
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 3, "clear_again");
    foreach (tbl[i]) begin
      drive_a(tbl[i].iv, tbl[i].pi, tbl[i].pe, tbl[i].idx, tbl[i].pd, tbl[i].clr);
      check(tbl[i].name, act_a(), exp_a(tbl[i].d, tbl[i].f, tbl[i].a, tbl[i].s, tbl[i].t));
    end

    // Lockout: third failure raises alarm; codes during lockout are ignored.
    code_a(8'h00);
    check("lock_fail1", act_a(), exp_a(0, 1, 0, 0, 2));
    code_a(8'h00);
    check("lock_fail2", act_a(), exp_a(0, 1, 0, 0, 1));
    code_a(8'h00);
    check("lock_enter", act_a(), exp_a(0, 1, 1, 0, 0));
    n_alarm = 1;
    guard = 0;
    while (bus_a.alarm && guard < 40) begin
      code_a(8'hAA);
      guard++;
      if (bus_a.alarm) n_alarm++;
    end
    check("alarm_length", 16'(n_alarm), 16'(LA));
    check("after_lockout", act_a(), exp_a(0, 0, 0, 0, 3));
    code_a(8'hAA);
    check("first_code_after_lockout", act_a(), exp_a(0, 0, 0, 1, 3));

    // Asynchronous reset mid-lockout restores the initial sequence.
    repeat (3) code_a(8'h00);
    check("relock", act_a(), exp_a(0, 1, 1, 0, 0));
    drive_a(0, 8'h00, 0, 0, 0, 0);
    drive_a(0, 8'h00, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check("reset_mid_lockout", act_a(), exp_a(0, 0, 0, 0, 3));
    @(negedge clk); reset = 1'b0;
    code_a(8'hAA);
    code_a(8'hCC);
    code_a(8'hF0);
    check("seq_init_restored", act_a(), exp_a(1, 0, 0, 3, 3));

    // Random traffic against the model.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      iv = 0; pe = 0; clr = 0;
      pi = 8'($urandom); idx = 2'($urandom_range(0, 3)); pd = 8'($urandom);
      if (r < 5) pe = 1'b1;
      else if (r < 15) clr = 1'b1;
      else if (r < 85) begin
        iv = 1'b1;
        if ($urandom_range(0, 4) != 0)
          pi = m_seq[(m_matched < int'(NA)) ? m_matched : 0];
      end
      drive_a(iv, pi, pe, idx, pd, clr);
      check("random", act_a(), exp_model());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
